// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the fetch PC, issues single-outstanding
// word requests to instruction memory, buffers returned words in a small
// prefetch FIFO and presents the head entry {pc, instr} to the decoder.
// Taken branches flush the FIFO and discard any response already in flight.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        instr_valid
);

  localparam int             CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_REQ   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Fetch control state
  state_t        r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_pend_pc;
  logic          r_out;        // a request is being held until its ack

  // Prefetch FIFO, entry 0 is always the head
  logic [31:0]   r_pc  [DEPTH];
  logic [31:0]   r_ins [DEPTH];
  logic [CW-1:0] r_count;

  // Registered decoder-facing outputs
  logic [31:0]   r_instruction;
  logic [31:0]   r_pc_out;
  logic          r_valid;

  // Next-state wires
  logic          w_pop;
  logic          w_issue;
  logic          w_ack;
  logic          w_push;
  logic [CW-1:0] w_wr_idx;
  logic [31:0]   w_pc_n  [DEPTH];
  logic [31:0]   w_ins_n [DEPTH];
  logic [CW-1:0] w_count_n;
  logic          w_valid_n;
  logic [31:0]   w_instr_n;
  logic [31:0]   w_pc_out_n;

  // The head leaves only when the decoder takes it and no redirect is flushing it.
  assign w_pop    = r_valid & ~stall & ~branch_taken;
  // Slot index after this cycle's pop; a new request may only start if a slot is free.
  assign w_wr_idx = r_count - CW'(w_pop);
  // A redirect cycle never starts a new request, so the next one goes to the target.
  assign w_issue  = (r_state == ST_REQ) & ~r_out & ~branch_taken & (w_wr_idx < DEPTH_C);
  assign imem_req  = r_out | w_issue;
  assign imem_addr = r_fetch_pc;
  assign w_ack     = imem_req & imem_ack;
  assign w_push    = w_ack & (r_state == ST_REQ) & ~branch_taken;

  assign instruction = r_instruction;
  assign pc_out      = r_pc_out;
  assign instr_valid = r_valid;

  // Next FIFO contents: redirect clears, otherwise shift out on pop then append on push.
  always_comb begin
    w_pc_n    = r_pc;
    w_ins_n   = r_ins;
    w_count_n = r_count;
    if (branch_taken) begin
      w_count_n = {CW{1'b0}};
    end else begin
      if (w_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          w_pc_n[i]  = r_pc[i + 1];
          w_ins_n[i] = r_ins[i + 1];
        end
      end else begin
        w_pc_n  = r_pc;
        w_ins_n = r_ins;
      end
      for (int i = 0; i < DEPTH; i++) begin
        w_pc_n[i]  = (w_push && (CW'(i) == w_wr_idx)) ? r_fetch_pc : w_pc_n[i];
        w_ins_n[i] = (w_push && (CW'(i) == w_wr_idx)) ? imem_rdata : w_ins_n[i];
      end
      w_count_n = w_wr_idx + CW'(w_push);
    end
  end

  // Head view of the next FIFO state; pc_out keeps its last value while empty.
  always_comb begin
    w_valid_n  = (w_count_n != {CW{1'b0}});
    w_instr_n  = w_valid_n ? w_ins_n[0] : NOP_INSTR;
    w_pc_out_n = w_valid_n ? w_pc_n[0]  : r_pc_out;
  end

  // FIFO storage and registered head outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]  <= 32'h0000_0000;
        r_ins[i] <= 32'h0000_0000;
      end
      r_count       <= {CW{1'b0}};
      r_valid       <= 1'b0;
      r_instruction <= NOP_INSTR;
      r_pc_out      <= RESET_PC;
    end else begin
      r_pc          <= w_pc_n;
      r_ins         <= w_ins_n;
      r_count       <= w_count_n;
      r_valid       <= w_valid_n;
      r_instruction <= w_instr_n;
      r_pc_out      <= w_pc_out_n;
    end
  end

  // Fetch FSM: PC advance, request hold, and redirect / flush handling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RESET;
      r_fetch_pc <= RESET_PC;
      r_pend_pc  <= RESET_PC;
      r_out      <= 1'b0;
    end else begin
      case (r_state)
        ST_RESET: begin
          r_state <= ST_REQ;
          r_out   <= 1'b0;
        end
        ST_REQ: begin
          if (branch_taken) begin
            if (imem_req && !imem_ack) begin
              // Old request must complete at its old address; park the target.
              r_state   <= ST_FLUSH;
              r_pend_pc <= branch_target;
              r_out     <= 1'b1;
            end else begin
              // Nothing pending, or its data arrives now and is dropped.
              r_fetch_pc <= branch_target;
              r_out      <= 1'b0;
            end
          end else if (w_ack) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
            r_out      <= 1'b0;
          end else begin
            r_out <= imem_req;
          end
        end
        ST_FLUSH: begin
          if (w_ack) begin
            // Stale data is dropped; a redirect in this very cycle wins.
            r_state    <= ST_REQ;
            r_out      <= 1'b0;
            r_fetch_pc <= branch_taken ? branch_target : r_pend_pc;
          end else if (branch_taken) begin
            r_pend_pc <= branch_target;
          end else begin
            r_pend_pc <= r_pend_pc;
          end
        end
        default: begin
          r_state <= ST_RESET;
          r_out   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: a memory model with random ack latency,
// random stall / redirect traffic, and a transaction-level reference model
// (queue of expected head PCs, next-fetch address, stale-request flag).
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          DEPTH     = 2;
  localparam logic [31:0] NOP_INSTR = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        instr_valid;

  instr_fetch #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH),
    .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .instruction  (instruction),
    .pc_out       (pc_out),
    .instr_valid  (instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int mem_wait = -1;

  // Reference model state
  logic [31:0] q_pc[$];
  logic [31:0] m_nf;
  logic [31:0] m_held;
  logic [31:0] m_last;
  logic [31:0] m_addr;
  bit          m_out;
  bit          m_stale;
  bit          m_rst_state;
  int          m_sz;
  int          m_pop;
  logic        m_req;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1000_0000;
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] r;
    case ($urandom_range(4))
      0: r = 32'h0000_0100;
      1: r = 32'h0000_0200;
      2: r = 32'h0000_0300;
      3: r = 32'hFFFF_FFF8;
      default: begin
        r = $urandom();
        r = r & 32'hFFFF_FFFC;
      end
    endcase
    return r;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: compare outputs on the falling edge, then apply this cycle's events.
  always @(negedge clk) begin
    if (!rst_n) begin
      check_val("rst_req", {31'd0, imem_req}, 32'd0);
      check_val("rst_addr", imem_addr, RESET_PC);
      check_val("rst_valid", {31'd0, instr_valid}, 32'd0);
      check_val("rst_instr", instruction, NOP_INSTR);
      check_val("rst_pc", pc_out, RESET_PC);
      q_pc.delete();
      m_nf        = RESET_PC;
      m_last      = RESET_PC;
      m_held      = RESET_PC;
      m_out       = 1'b0;
      m_stale     = 1'b0;
      m_rst_state = 1'b1;
    end else begin
      m_sz = q_pc.size();
      check_val("valid", {31'd0, instr_valid}, {31'd0, (m_sz != 0)});
      if (m_sz != 0) begin
        check_val("pc_out", pc_out, q_pc[0]);
        check_val("instr", instruction, mem_word(q_pc[0]));
        m_last = q_pc[0];
      end else begin
        check_val("nop_instr", instruction, NOP_INSTR);
        check_val("hold_pc", pc_out, m_last);
      end
      m_pop = ((m_sz != 0) && !stall && !branch_taken) ? 1 : 0;
      if (m_rst_state) m_req = 1'b0;
      else if (m_out) m_req = 1'b1;
      else m_req = (!branch_taken && ((m_sz - m_pop) < DEPTH));
      check_val("req", {31'd0, imem_req}, {31'd0, m_req});
      m_addr = m_out ? m_held : m_nf;
      if (m_req) check_val("addr", imem_addr, m_addr);
      // Events at the coming rising edge
      if (m_rst_state) begin
        m_rst_state = 1'b0;
      end else if (branch_taken) begin
        if (m_req && imem_ack) begin
          m_out   = 1'b0;
          m_stale = 1'b0;
        end else if (m_req) begin
          m_out   = 1'b1;
          m_stale = 1'b1;
          m_held  = m_addr;
        end
        q_pc.delete();
        m_nf = branch_target;
      end else begin
        if (m_pop != 0) void'(q_pc.pop_front());
        if (m_req && imem_ack) begin
          if (!m_stale) begin
            q_pc.push_back(m_addr);
            m_nf = m_addr + 32'd4;
          end
          m_out   = 1'b0;
          m_stale = 1'b0;
        end else if (m_req) begin
          m_out  = 1'b1;
          m_held = m_addr;
        end
      end
    end
  end

  task automatic drive_cycles(input int n, input int dmin, input int dmax, input int pst, input int pbr);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (imem_ack) mem_wait = -1;
      else if (mem_wait > 0) mem_wait--;
      #1;
      stall         = ($urandom_range(99) < pst);
      branch_taken  = ($urandom_range(99) < pbr);
      branch_target = pick_target();
      #1;
      if (imem_req) begin
        if (mem_wait < 0) mem_wait = $urandom_range(dmax, dmin);
        if (mem_wait == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = $urandom();
        end
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom();
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_n        = 1'b0;
    stall        = 1'b0;
    branch_taken = 1'b0;
    imem_ack     = 1'b1;
    imem_rdata   = $urandom();
    mem_wait     = -1;
    repeat (cycles) @(posedge clk);
    #2;
    imem_ack = 1'b0;
    rst_n    = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    imem_ack      = 1'b0;
    imem_rdata    = 32'h0000_0000;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0000_0000;
    do_reset(3);
    drive_cycles(20, 0, 0, 0, 0);      // zero-wait streaming
    drive_cycles(40, 3, 3, 0, 0);      // fixed 3-cycle ack latency
    drive_cycles(60, 0, 0, 40, 0);     // stalls with zero-wait memory
    drive_cycles(300, 0, 3, 25, 10);   // mixed traffic
    drive_cycles(300, 2, 3, 10, 30);   // redirect-heavy, frequent flush
    drive_cycles(300, 0, 4, 50, 15);
    // Reset asserted while a request is outstanding
    drive_cycles(4, 3, 3, 0, 0);
    @(posedge clk);
    #3;
    rst_n      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = $urandom();
    #1;
    check_val("async_req", {31'd0, imem_req}, 32'd0);
    check_val("async_addr", imem_addr, RESET_PC);
    check_val("async_valid", {31'd0, instr_valid}, 32'd0);
    check_val("async_instr", instruction, NOP_INSTR);
    check_val("async_pc", pc_out, RESET_PC);
    do_reset(3);
    drive_cycles(400, 0, 3, 30, 15);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
